pll_reset_sequencer: RTL and testbench



---
 rtl/pll_reset_sequencer.sv | 132 +++++++++++++
 tb/tb_pll_reset_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset pulse, lock qualification and system reset release.
// Optional build macro PLL_SEQ_RELOCK_EN: lock loss in RUN re-runs the PLL reset sequence.
`timescale 1ns/1ps
module pll_reset_sequencer #(
  parameter int STABLE_CYCLES  = 2700,
  parameter int LOCK_TIMEOUT   = 27000,
  parameter int PLL_RST_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lock,
  output logic       pll_reset,
  output logic       sys_rst_n,
  output logic       ready,
  output logic [3:0] retry_cnt,
  output logic       lock_lost
);

  localparam int RW = (PLL_RST_CYCLES > 1) ? $clog2(PLL_RST_CYCLES) : 1;
  localparam int TW = (LOCK_TIMEOUT   > 1) ? $clog2(LOCK_TIMEOUT)   : 1;
  localparam int SW = (STABLE_CYCLES  > 1) ? $clog2(STABLE_CYCLES)  : 1;

  localparam logic [RW-1:0] RST_LAST    = RW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {PLL_RST, WAIT_LOCK, STABLE, RUN} state_t;

  state_t          state_q, state_d;
  logic            lock_meta_q, lock_s_q;
  logic [RW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [SW-1:0]   stab_q, stab_d;
  logic [3:0]      retry_q, retry_d;
  logic            lost_q, lost_d;
  logic            pll_reset_q, sys_rst_n_q, ready_q;

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    timer_d   = timer_q;
    stab_d    = stab_q;
    retry_d   = retry_q;
    lost_d    = lost_q;
    case (state_q)
      PLL_RST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d   = WAIT_LOCK;
          rst_cnt_d = '0;
          timer_d   = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RW'(1);
        end
      end
      WAIT_LOCK: begin
        // Lock is tested before the timeout so a coincident lock is never retried.
        if (lock_s_q) begin
          state_d = STABLE;
          timer_d = '0;
          stab_d  = '0;
        end else if (timer_q == TIMER_LAST) begin
          state_d   = PLL_RST;
          rst_cnt_d = '0;
          timer_d   = '0;
          if (retry_q != 4'hF) retry_d = retry_q + 4'd1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      STABLE: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
          stab_d  = '0;
        end else if (stab_q == STABLE_LAST) begin
          state_d = RUN;
          stab_d  = '0;
        end else begin
          stab_d = stab_q + SW'(1);
        end
      end
      RUN: begin
        if (!lock_s_q) begin
          lost_d = 1'b1;
`ifdef PLL_SEQ_RELOCK_EN
          state_d   = PLL_RST;
          rst_cnt_d = '0;
`else
          state_d   = RUN;
`endif
        end
      end
      default: state_d = PLL_RST;
    endcase
  end

  // Outputs are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PLL_RST;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      rst_cnt_q   <= '0;
      timer_q     <= '0;
      stab_q      <= '0;
      retry_q     <= 4'd0;
      lost_q      <= 1'b0;
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_meta_q <= lock;
      lock_s_q    <= lock_meta_q;
      rst_cnt_q   <= rst_cnt_d;
      timer_q     <= timer_d;
      stab_q      <= stab_d;
      retry_q     <= retry_d;
      lost_q      <= lost_d;
      pll_reset_q <= (state_d == PLL_RST);
      sys_rst_n_q <= (state_d == RUN);
      ready_q     <= (state_d == RUN);
    end
  end

  assign pll_reset = pll_reset_q;
  assign sys_rst_n = sys_rst_n_q;
  assign ready     = ready_q;
  assign retry_cnt = retry_q;
  assign lock_lost = lost_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - directed bench for pll_reset_sequencer (8/32/4 configuration).
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

  logic       clk;
  logic       rst_n;
  logic       lock;
  logic       pll_reset;
  logic       sys_rst_n;
  logic       ready;
  logic [3:0] retry_cnt;
  logic       lock_lost;

  int checks;
  int errors;
  int cyc;

  pll_reset_sequencer #(
    .STABLE_CYCLES (8),
    .LOCK_TIMEOUT  (32),
    .PLL_RST_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .lock     (lock),
    .pll_reset(pll_reset),
    .sys_rst_n(sys_rst_n),
    .ready    (ready),
    .retry_cnt(retry_cnt),
    .lock_lost(lock_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Edge n is the n-th rising clk edge after rst_n release; sampling is 1 ns after it.
  task automatic adv_to(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic hold_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_rst(input logic lock_val);
    lock  = lock_val;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    lock   = 1'b0;
    hold_reset();
    chk("rst_pll_reset", pll_reset, 1);
    chk("rst_sys_rst_n", sys_rst_n, 0);
    chk("rst_ready",     ready,     0);
    chk("rst_retry",     retry_cnt, 0);
    chk("rst_lock_lost", lock_lost, 0);

    // Lock present from release: 4-cycle PLL reset, sync, 8-cycle window, RUN at edge 13.
    release_rst(1'b1);
    adv_to(1);  chk("t1_pll_e1",  pll_reset, 1);
    adv_to(3);  chk("t1_pll_e3",  pll_reset, 1);
    adv_to(4);  chk("t1_pll_e4",  pll_reset, 0);
                chk("t1_sys_e4",  sys_rst_n, 0);
    adv_to(12); chk("t1_sys_e12", sys_rst_n, 0);
                chk("t1_rdy_e12", ready,     0);
    adv_to(13); chk("t1_sys_e13", sys_rst_n, 1);
                chk("t1_rdy_e13", ready,     1);
                chk("t1_retry",   retry_cnt, 0);
                chk("t1_pll_e13", pll_reset, 0);

    // Lock loss in RUN: seen through the synchronizer at edge 16.
    lock = 1'b0;
    adv_to(15); chk("t2_lost_e15", lock_lost, 0);
                chk("t2_sys_e15",  sys_rst_n, 1);
    adv_to(16); chk("t2_lost_e16", lock_lost, 1);
`ifdef PLL_SEQ_RELOCK_EN
                chk("t2_sys_e16",  sys_rst_n, 0);
                chk("t2_rdy_e16",  ready,     0);
                chk("t2_pll_e16",  pll_reset, 1);
    adv_to(19); chk("t2_pll_e19",  pll_reset, 1);
    adv_to(20); chk("t2_pll_e20",  pll_reset, 0);
                chk("t2_retry",    retry_cnt, 0);
`else
                chk("t2_sys_e16",  sys_rst_n, 1);
                chk("t2_rdy_e16",  ready,     1);
                chk("t2_pll_e16",  pll_reset, 0);
    adv_to(20); lock = 1'b1;
    adv_to(30); chk("t2_lost_sticky", lock_lost, 1);
                chk("t2_sys_e30",     sys_rst_n, 1);
`endif

    // Asynchronous reset clears the sticky flag without a clock edge.
    rst_n = 1'b0;
    #1;
    chk("t3_async_lost", lock_lost, 0);
    chk("t3_async_sys",  sys_rst_n, 0);

    // One-cycle lock glitch at stable count 5 restarts the full window: RUN at edge 20.
    hold_reset();
    release_rst(1'b1);
    adv_to(8);  lock = 1'b0;
    adv_to(9);  lock = 1'b1;
    adv_to(13); chk("t3_sys_e13", sys_rst_n, 0);
    adv_to(19); chk("t3_sys_e19", sys_rst_n, 0);
    adv_to(20); chk("t3_sys_e20", sys_rst_n, 1);
                chk("t3_rdy_e20", ready,     1);

    // lock_s rises exactly when the timer hits its last value: lock wins at edge 36.
    hold_reset();
    release_rst(1'b0);
    adv_to(33); lock = 1'b1;
    adv_to(35); chk("t4_pll_e35",   pll_reset, 0);
    adv_to(36); chk("t4_pll_e36",   pll_reset, 0);
                chk("t4_retry_e36", retry_cnt, 0);
    adv_to(43); chk("t4_sys_e43",   sys_rst_n, 0);
    adv_to(44); chk("t4_sys_e44",   sys_rst_n, 1);
                chk("t4_retry_e44", retry_cnt, 0);

    // Lock absent for 100 cycles: retries every 36 cycles, then RUN at edge 111.
    hold_reset();
    release_rst(1'b0);
    adv_to(35);  chk("t5_pll_e35",    pll_reset, 0);
                 chk("t5_retry_e35",  retry_cnt, 0);
    adv_to(36);  chk("t5_pll_e36",    pll_reset, 1);
                 chk("t5_retry_e36",  retry_cnt, 1);
    adv_to(39);  chk("t5_pll_e39",    pll_reset, 1);
    adv_to(40);  chk("t5_pll_e40",    pll_reset, 0);
    adv_to(71);  chk("t5_pll_e71",    pll_reset, 0);
    adv_to(72);  chk("t5_pll_e72",    pll_reset, 1);
                 chk("t5_retry_e72",  retry_cnt, 2);
    adv_to(76);  chk("t5_pll_e76",    pll_reset, 0);
    adv_to(100); lock = 1'b1;
    adv_to(110); chk("t5_sys_e110",   sys_rst_n, 0);
    adv_to(111); chk("t5_sys_e111",   sys_rst_n, 1);
                 chk("t5_rdy_e111",   ready,     1);
                 chk("t5_retry_e111", retry_cnt, 2);

    // Twenty timeouts saturate the retry count, then rst_n mid-STABLE clears everything.
    hold_reset();
    release_rst(1'b0);
    adv_to(504); chk("t6_retry_e504", retry_cnt, 14);
    adv_to(540); chk("t6_retry_e540", retry_cnt, 15);
    adv_to(720); chk("t6_retry_e720", retry_cnt, 15);
    lock = 1'b1;
    adv_to(728); chk("t6_sys_stable",   sys_rst_n, 0);
                 chk("t6_pll_stable",   pll_reset, 0);
                 chk("t6_retry_stable", retry_cnt, 15);
    rst_n = 1'b0;
    #1;
    chk("t6_async_pll",   pll_reset, 1);
    chk("t6_async_sys",   sys_rst_n, 0);
    chk("t6_async_rdy",   ready,     0);
    chk("t6_async_retry", retry_cnt, 0);
    chk("t6_async_lost",  lock_lost, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
